// File: rtl/alarm_pkg.sv
// Shared definitions for the anti-theft alarm timer.
//   - interval_e      : duration-select codes driven by the alarm FSM
//   - DUR_*           : power-on default durations in seconds
//   - timer_state_e   : timer FSM state encoding
//   - default_duration: maps an interval code to its default duration
package alarm_pkg;

  typedef enum logic [1:0] {
    INT_ARM_DELAY       = 2'b00,
    INT_DRIVER_DELAY    = 2'b01,
    INT_PASSENGER_DELAY = 2'b10,
    INT_ALARM_ON        = 2'b11
  } interval_e;

  localparam int unsigned DUR_ARM_DELAY       = 6;
  localparam int unsigned DUR_DRIVER_DELAY    = 8;
  localparam int unsigned DUR_PASSENGER_DELAY = 15;
  localparam int unsigned DUR_ALARM_ON        = 10;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StCount   = 2'b01,
    StExpired = 2'b10
  } timer_state_e;

  function automatic int unsigned default_duration(input interval_e sel);
    int unsigned dur;
    case (sel)
      INT_ARM_DELAY:       dur = DUR_ARM_DELAY;
      INT_DRIVER_DELAY:    dur = DUR_DRIVER_DELAY;
      INT_PASSENGER_DELAY: dur = DUR_PASSENGER_DELAY;
      INT_ALARM_ON:        dur = DUR_ALARM_ON;
      default:             dur = DUR_ARM_DELAY;
    endcase
    return dur;
  endfunction

endpackage

// File: rtl/alarm_timer_if.sv
// Timer request/response bundle between the alarm FSM (master) and alarm_timer (slave).
//   start_timer, interval            : run request and duration select
//   reprogram, time_param_sel/value  : duration-table write port
//   one_hz_enable, expired, remaining: tick, expiry flag, seconds left
interface alarm_timer_if #(
  parameter int unsigned T_W = 4
);
  logic           start_timer;
  logic [1:0]     interval;
  logic           reprogram;
  logic [1:0]     time_param_sel;
  logic [T_W-1:0] time_value;
  logic           one_hz_enable;
  logic           expired;
  logic [T_W-1:0] remaining;

  modport master (
    output start_timer, interval, reprogram, time_param_sel, time_value,
    input  one_hz_enable, expired, remaining
  );

  modport slave (
    input  start_timer, interval, reprogram, time_param_sel, time_value,
    output one_hz_enable, expired, remaining
  );
endinterface

// File: rtl/one_hz_tick.sv
// Free-running clock divider producing a one-cycle tick every CLK_FREQ cycles.
//   clock, reset  : system clock, synchronous active-high reset
//   one_hz_enable : high while the divider sits at CLK_FREQ-1
module one_hz_tick #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  output logic one_hz_enable
);

  localparam int unsigned DivW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_FREQ - 1);

  logic [DivW-1:0] div_q, div_d;

  always_comb begin
    div_d = (div_q == DivMax) ? '0 : div_q + DivW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign one_hz_enable = (div_q == DivMax);

endmodule

// File: rtl/alarm_timer.sv
// Timebase and interval timer for the anti-theft controller.
//   clock, reset : system clock, synchronous active-high reset (highest priority)
//   bus (slave)  : start_timer/interval request in, expired/remaining/one_hz_enable out,
//                  reprogram/time_param_sel/time_value table write port
// Optional feature: define ALARM_TIMER_REPROG_EN to make the duration table writable at run
// time; otherwise the table is fixed at the package defaults and the write port is ignored.
module alarm_timer
  import alarm_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned T_W      = 4
) (
  input logic          clock,
  input logic          reset,
  alarm_timer_if.slave bus
);

  logic tick;

  one_hz_tick #(
    .CLK_FREQ(CLK_FREQ)
  ) u_one_hz_tick (
    .clock        (clock),
    .reset        (reset),
    .one_hz_enable(tick)
  );

  assign bus.one_hz_enable = tick;

  // Duration table
  logic [T_W-1:0] tbl [4];

`ifdef ALARM_TIMER_REPROG_EN
  // A load in the same cycle as a write reads the old entry, since tbl is registered.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        tbl[i] <= T_W'(default_duration(interval_e'(i)));
      end
    end else if (bus.reprogram) begin
      tbl[bus.time_param_sel] <= bus.time_value;
    end
  end
`else
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      tbl[i] = T_W'(default_duration(interval_e'(i)));
    end
  end

  logic unused_reprog;
  assign unused_reprog = ^{bus.reprogram, bus.time_param_sel, bus.time_value};
`endif

  // Timer FSM
  timer_state_e   state_q, state_d;
  logic [T_W-1:0] rem_q, rem_d;
  interval_e      lat_q, lat_d;
  interval_e      itv;
  logic [T_W-1:0] load_dur;
  logic           load;

  assign itv      = interval_e'(bus.interval);
  assign load_dur = tbl[bus.interval];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      rem_q   <= '0;
      lat_q   <= INT_ARM_DELAY;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    lat_d   = lat_q;
    load    = 1'b0;
    case (state_q)
      StIdle: begin
        rem_d = '0;
        if (bus.start_timer) load = 1'b1;
      end
      StCount: begin
        if (!bus.start_timer) begin
          state_d = StIdle;
          rem_d   = '0;
        end else if (tick) begin
          if (rem_q <= T_W'(1)) begin
            rem_d   = '0;
            state_d = StExpired;
          end else begin
            rem_d = rem_q - T_W'(1);
          end
        end
      end
      StExpired: begin
        if (!bus.start_timer) begin
          state_d = StIdle;
          rem_d   = '0;
        end else if (itv != lat_q) begin
          // Chained delay: requester moved on to the next interval.
          load = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        rem_d   = '0;
      end
    endcase

    // A tick in the load cycle is deliberately not counted.
    if (load) begin
      lat_d   = itv;
      rem_d   = load_dur;
      state_d = (load_dur == '0) ? StExpired : StCount;
    end
  end

  // Combinational so a stale expiry never shows in the cycle the interval changes.
  always_comb begin
    bus.expired   = (state_q == StExpired) && bus.start_timer && (itv == lat_q);
    bus.remaining = rem_q;
  end

endmodule

// File: tb/tb_alarm_timer.sv
// Self-checking bench for alarm_timer with CLK_FREQ = 4: directed scenarios plus random
// stimulus, all compared against a seconds-level behavioural model.
module tb_alarm_timer;

  localparam int unsigned CF = 4;
  localparam int unsigned TW = 4;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  alarm_timer_if #(.T_W(TW)) bus ();

  alarm_timer #(
    .CLK_FREQ(CF),
    .T_W     (TW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: seconds left, whether the delay has fired, latched interval,
  // and the cycle position within the current second.
  int m_phase;
  int m_left;
  bit m_running;
  bit m_fired;
  int m_lat;
  int m_tbl [4];
  int defaults [4] = '{6, 8, 15, 10};

  function automatic void model_reset();
    m_phase   = 0;
    m_left    = 0;
    m_running = 0;
    m_fired   = 0;
    m_lat     = 0;
    for (int i = 0; i < 4; i++) m_tbl[i] = defaults[i];
  endfunction

  function automatic void model_edge();
    int itv;
    bit second_done;
    itv = int'(bus.interval);
    if (reset) begin
      model_reset();
      return;
    end
    second_done = (m_phase == CF - 1);
    if (!bus.start_timer) begin
      m_running = 0;
      m_fired   = 0;
      m_left    = 0;
    end else if ((!m_running && !m_fired) || (m_fired && itv != m_lat)) begin
      m_lat     = itv;
      m_left    = m_tbl[itv];
      m_running = (m_left != 0);
      m_fired   = (m_left == 0);
    end else if (m_running && second_done) begin
      if (m_left <= 1) begin
        m_left    = 0;
        m_running = 0;
        m_fired   = 1;
      end else begin
        m_left = m_left - 1;
      end
    end
`ifdef ALARM_TIMER_REPROG_EN
    if (bus.reprogram) m_tbl[int'(bus.time_param_sel)] = int'(bus.time_value);
`endif
    m_phase = (m_phase + 1) % CF;
  endfunction

  // Compare at the falling edge, then advance one clock and update the model.
  task automatic cycle();
    @(negedge clock);
    check("one_hz_enable", 32'(bus.one_hz_enable), 32'(m_phase == CF - 1));
    check("remaining", 32'(bus.remaining), 32'(m_left));
    check("expired", 32'(bus.expired),
          32'(m_fired && bus.start_timer && int'(bus.interval) == m_lat));
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    reset              = 1'b1;
    bus.start_timer    = 1'b0;
    bus.interval       = 2'b00;
    bus.reprogram      = 1'b0;
    bus.time_param_sel = 2'b00;
    bus.time_value     = '0;
    @(posedge clock);
    @(posedge clock);
    model_reset();
    #1;
    reset = 1'b0;

    // Reset state, then divider phase over a few seconds
    check("rst_remaining", 32'(bus.remaining), 32'd0);
    check("rst_expired", 32'(bus.expired), 32'd0);
    check("rst_tick", 32'(bus.one_hz_enable), 32'd0);
    run(12);

    // Driver delay held to expiry
    bus.start_timer = 1'b1;
    bus.interval    = 2'b01;
    cycle();
    check("load_driver", 32'(bus.remaining), 32'd8);
    run(40);
    check("driver_expired", 32'(bus.expired), 32'd1);

    // Chained delay to alarm-on
    bus.interval = 2'b11;
    #1;
    check("chain_drop", 32'(bus.expired), 32'd0);
    cycle();
    check("chain_load", 32'(bus.remaining), 32'd10);
    run(45);
    check("alarm_expired", 32'(bus.expired), 32'd1);

    // Passenger delay, interval change mid-count is ignored
    bus.interval = 2'b10;
    cycle();
    check("pass_load", 32'(bus.remaining), 32'd15);
    run(9);
    bus.interval = 2'b01;
    for (int i = 0; i < 100 && m_left != 3; i++) cycle();
    check("reach_3", 32'(bus.remaining), 32'd3);

    // Abort, then restart reloads the full duration
    bus.start_timer = 1'b0;
    cycle();
    check("abort_rem", 32'(bus.remaining), 32'd0);
    check("abort_exp", 32'(bus.expired), 32'd0);
    bus.start_timer = 1'b1;
    cycle();
    check("restart", 32'(bus.remaining), 32'd8);
    run(6);

    // Reprogram passenger entry to 3
    bus.start_timer    = 1'b0;
    bus.reprogram      = 1'b1;
    bus.time_param_sel = 2'b10;
    bus.time_value     = 4'd3;
    cycle();
    bus.reprogram   = 1'b0;
    bus.start_timer = 1'b1;
    bus.interval    = 2'b10;
    cycle();
`ifdef ALARM_TIMER_REPROG_EN
    check("reprog_load", 32'(bus.remaining), 32'd3);
`else
    check("reprog_load", 32'(bus.remaining), 32'd15);
`endif
    run(20);
    reset           = 1'b1;
    bus.start_timer = 1'b0;
    cycle();
    reset = 1'b0;
    check("reset_mid", 32'(bus.remaining), 32'd0);
    bus.start_timer = 1'b1;
    cycle();
    check("reset_restore", 32'(bus.remaining), 32'd15);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 59) == 0) bus.start_timer = ~bus.start_timer;
      if ($urandom_range(0, 24) == 0) bus.interval = 2'($urandom_range(0, 3));
      bus.reprogram      = ($urandom_range(0, 15) == 0);
      bus.time_param_sel = 2'($urandom_range(0, 3));
      bus.time_value     = TW'($urandom_range(0, 15));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
